// File: rtl/rx_fsm_pkg.sv
// Shared encodings for the RX flow controller: load codes, TLP kinds and FSM states.
package rx_fsm_pkg;

  localparam logic [2:0] CTL_IDLE  = 3'b000;
  localparam logic [2:0] CTL_H1    = 3'b001;
  localparam logic [2:0] CTL_H2    = 3'b010;
  localparam logic [2:0] CTL_DATA3 = 3'b011;
  localparam logic [2:0] CTL_DATA4 = 3'b100;

  localparam logic [1:0] OP_MRD   = 2'b00;
  localparam logic [1:0] OP_MWR3  = 2'b01;
  localparam logic [1:0] OP_MWR4  = 2'b10;
  localparam logic [1:0] OP_OTHER = 2'b11;

  typedef enum logic [2:0] {
    S_H1    = 3'd0,
    S_H2    = 3'd1,
    S_D3    = 3'd2,
    S_D4    = 3'd3,
    S_PUSH  = 3'd4,
    S_DRAIN = 3'd5
  } rx_state_e;

  // Where the second header beat leads, given the latched TLP kind and rx_last.
  function automatic rx_state_e h2_next(input logic [1:0] kind, input logic last);
    rx_state_e nxt;
    case (kind)
      OP_MRD:   nxt = last ? S_PUSH : S_DRAIN;
      OP_MWR3:  nxt = last ? S_H1   : S_D3;
      OP_MWR4:  nxt = last ? S_H1   : S_D4;
      OP_OTHER: nxt = last ? S_H1   : S_DRAIN;
      default:  nxt = S_H1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rx_fsm.sv
// Receive-side TLP flow controller: paces AXI RX, emits per-beat load codes and
// requests a TX header push for memory reads.
module rx_fsm
  import rx_fsm_pkg::*;
#(
  parameter int keep_width = 8
) (
  input  logic                  rx_clk,
  input  logic                  rx_reset,
  input  logic                  rx_valid,
  input  logic [keep_width-1:0] rx_keep,
  input  logic                  rx_last,
  output logic                  rx_ready,
  input  logic                  tx_header_fifo_ready,
  output logic                  tx_header_fifo_valid,
  input  logic                  ocp_ready,
  input  logic [1:0]            optype,
  output logic [2:0]            ocp_reg_ctl
);

  rx_state_e  state_r;
  rx_state_e  next_state_s;
  logic [1:0] kind_r;
  logic [1:0] next_kind_s;
  logic       rx_ready_s;
  logic       fifo_valid_s;
  logic [2:0] ctl_s;
  logic       acc_s;

  // Byte enables are reserved; fold them so they are visibly consumed.
  logic       keep_unused_s;
  assign keep_unused_s = ^rx_keep;

  // State and latched TLP kind register with synchronous reset.
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state_r <= S_H1;
      kind_r  <= OP_MRD;
    end else begin
      state_r <= next_state_s;
      kind_r  <= next_kind_s;
    end
  end

  // Next-state and kind capture; rx_valid low (no acc) holds everything.
  always_comb begin
    next_state_s = state_r;
    next_kind_s  = kind_r;
    case (state_r)
      S_H1: begin
        if (acc_s) begin
          next_kind_s  = optype;
          next_state_s = rx_last ? S_H1 : S_H2;
        end else begin
          next_state_s = S_H1;
        end
      end
      S_H2: begin
        if (acc_s) begin
          next_state_s = h2_next(kind_r, rx_last);
        end else begin
          next_state_s = S_H2;
        end
      end
      S_D3, S_D4, S_DRAIN: begin
        if (acc_s && rx_last) begin
          next_state_s = S_H1;
        end else begin
          next_state_s = state_r;
        end
      end
      S_PUSH: begin
        if (tx_header_fifo_ready) begin
          next_state_s = S_H1;
        end else begin
          next_state_s = S_PUSH;
        end
      end
      default: begin
        next_state_s = S_H1;
      end
    endcase
  end

  // Outputs: reset forces everything quiet; ctl is only non-IDLE on an accepted beat.
  always_comb begin
    rx_ready_s   = 1'b0;
    fifo_valid_s = 1'b0;
    ctl_s        = CTL_IDLE;
    if (rx_reset) begin
      rx_ready_s   = 1'b0;
      fifo_valid_s = 1'b0;
    end else begin
      case (state_r)
        S_H1, S_H2, S_DRAIN: rx_ready_s = 1'b1;
        S_D3, S_D4:          rx_ready_s = ocp_ready;
        S_PUSH:              fifo_valid_s = 1'b1;
        default:             rx_ready_s = 1'b0;
      endcase
    end
    acc_s = rx_valid & rx_ready_s;
    if (acc_s) begin
      case (state_r)
        S_H1:    ctl_s = CTL_H1;
        S_H2:    ctl_s = CTL_H2;
        S_D3:    ctl_s = CTL_DATA3;
        S_D4:    ctl_s = CTL_DATA4;
        default: ctl_s = CTL_IDLE;
      endcase
    end else begin
      ctl_s = CTL_IDLE;
    end
  end

  assign rx_ready             = rx_ready_s;
  assign tx_header_fifo_valid = fifo_valid_s;
  assign ocp_reg_ctl          = ctl_s;

endmodule

// File: tb/tb_rx_fsm.sv
// Bench for rx_fsm: directed TLP scenarios plus randomized traffic against a beat-index model.
module tb_rx_fsm;

  logic       rx_clk = 1'b0;
  logic       rx_reset;
  logic       rx_valid;
  logic [7:0] rx_keep;
  logic       rx_last;
  logic       rx_ready;
  logic       tx_header_fifo_ready;
  logic       tx_header_fifo_valid;
  logic       ocp_ready;
  logic [1:0] optype;
  logic [2:0] ocp_reg_ctl;

  int checks_total  = 0;
  int checks_passed = 0;

  // Model: beats taken in current TLP, its kind, and whether a header push is pending.
  int m_idx  = 0;
  int m_kind = 0;
  bit m_push = 1'b0;

  // Observations from the most recent cycle, for directed scenario checks.
  logic [2:0] last_ctl;
  logic       last_fv;
  logic       last_rdy;

  always #5 rx_clk = ~rx_clk;

  rx_fsm #(.keep_width(8)) dut (
    .rx_clk               (rx_clk),
    .rx_reset             (rx_reset),
    .rx_valid             (rx_valid),
    .rx_keep              (rx_keep),
    .rx_last              (rx_last),
    .rx_ready             (rx_ready),
    .tx_header_fifo_ready (tx_header_fifo_ready),
    .tx_header_fifo_valid (tx_header_fifo_valid),
    .ocp_ready            (ocp_ready),
    .optype               (optype),
    .ocp_reg_ctl          (ocp_reg_ctl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic cyc(input bit v, input bit l, input logic [1:0] op,
                     input bit ocp, input bit ff, input bit rst);
    int  e_rdy, e_fv, e_ctl;
    bit  data_phase, acc;
    rx_valid = v; rx_last = l; optype = op; ocp_ready = ocp;
    tx_header_fifo_ready = ff; rx_reset = rst; rx_keep = 8'($urandom);
    #1;
    data_phase = (m_idx >= 2) && (m_kind == 1 || m_kind == 2);
    if (rst) begin
      e_rdy = 0; e_fv = 0;
    end else if (m_push) begin
      e_rdy = 0; e_fv = 1;
    end else begin
      e_rdy = data_phase ? int'(ocp) : 1; e_fv = 0;
    end
    acc = v && (e_rdy == 1);
    if (!acc)            e_ctl = 0;
    else if (m_idx == 0) e_ctl = 1;
    else if (m_idx == 1) e_ctl = 2;
    else if (m_kind == 1) e_ctl = 3;
    else if (m_kind == 2) e_ctl = 4;
    else                 e_ctl = 0;
    chk("rx_ready", 32'(rx_ready), 32'(e_rdy));
    chk("fifo_valid", 32'(tx_header_fifo_valid), 32'(e_fv));
    chk("ocp_reg_ctl", 32'(ocp_reg_ctl), 32'(e_ctl));
    last_ctl = ocp_reg_ctl; last_fv = tx_header_fifo_valid; last_rdy = rx_ready;
    @(posedge rx_clk);
    if (rst) begin
      m_idx = 0; m_kind = 0; m_push = 1'b0;
    end else if (m_push) begin
      if (ff) m_push = 1'b0;
    end else if (acc) begin
      if (m_idx == 0) begin
        m_kind = int'(op);
        m_idx  = l ? 0 : 1;
      end else if (m_idx == 1) begin
        if (l) begin
          m_idx = 0;
          if (m_kind == 0) m_push = 1'b1;
        end else begin
          m_idx = 2;
        end
      end else if (l) begin
        m_idx = 0;
      end
    end
    @(negedge rx_clk);
  endtask

  initial begin
    int fv_cycles, ctl_beats, acc_beats;
    logic [2:0] ctl_log [5];
    logic [2:0] exp5 [5];
    exp5[0] = 3'b001; exp5[1] = 3'b010; exp5[2] = 3'b000; exp5[3] = 3'b000; exp5[4] = 3'b000;
    @(negedge rx_clk);

    // 1: reset two cycles then idle
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("t1_ready", 32'(last_rdy), 32'd1);
    chk("t1_ctl", 32'(last_ctl), 32'd0);
    chk("t1_fv", 32'(last_fv), 32'd0);

    // 2: MRd, 2 beats, FIFO busy for 3 cycles
    cyc(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("t2_h1", 32'(last_ctl), 32'd1);
    cyc(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("t2_h2", 32'(last_ctl), 32'd2);
    fv_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 2'b11, 1'b1, (i == 3), 1'b0);
      if (last_fv && !last_rdy) fv_cycles++;
    end
    chk("t2_push_cycles", 32'(fv_cycles), 32'd4);
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("t2_back_ready", 32'(last_rdy), 32'd1);

    // 3: MWr 3DW, 4 beats, ocp_ready low for 2 cycles on beat 3
    ctl_beats = 0;
    cyc(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0); if (last_ctl != 3'b000) ctl_beats++;
    cyc(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0); if (last_ctl != 3'b000) ctl_beats++;
    cyc(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0); if (last_ctl != 3'b000) ctl_beats++;
    chk("t3_stall_ready", 32'(last_rdy), 32'd0);
    cyc(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0); if (last_ctl != 3'b000) ctl_beats++;
    cyc(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0); if (last_ctl != 3'b000) ctl_beats++;
    chk("t3_d3", 32'(last_ctl), 32'd3);
    cyc(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0); if (last_ctl != 3'b000) ctl_beats++;
    chk("t3_d3_last", 32'(last_ctl), 32'd3);
    chk("t3_beats", 32'(ctl_beats), 32'd4);

    // 4: MWr 4DW, 3 beats
    cyc(1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    chk("t4_d4", 32'(last_ctl), 32'd4);

    // 5: other TLP, 5 beats drained, then new header
    acc_beats = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, (i == 4), 2'b11, 1'b0, 1'b0, 1'b0);
      ctl_log[i] = last_ctl;
      if (last_rdy) acc_beats++;
    end
    for (int i = 0; i < 5; i++) chk($sformatf("t5_ctl%0d", i), 32'(ctl_log[i]), 32'(exp5[i]));
    chk("t5_accepted", 32'(acc_beats), 32'd5);
    cyc(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    chk("t5_next_h1", 32'(last_ctl), 32'd1);

    // 6: reset during beat 3 of a 4DW write
    cyc(1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1);
    chk("t6_reset_ctl", 32'(last_ctl), 32'd0);
    cyc(1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    chk("t6_after_h1", 32'(last_ctl), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), 2'($urandom),
          ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
